seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: the a/b/op bundle is valid.
REQ-005 SHALL have port in_ready, output, 1: the block accepts a bundle this cycle.
REQ-006 SHALL have ports a and b, input, WIDTH each: unsigned operands.
REQ-007 SHALL have port op, input, 4: opcode.
REQ-008 SHALL have port out_valid, output, 1: result/flags are valid.
REQ-009 SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-010 SHALL have port result, output, 2*WIDTH: operation result, zero-extended.
REQ-011 SHALL have port carry, output, 1: carry out (ADD), borrow (SUB), or bit shifted out (SHL/SHR).
REQ-012 SHALL have port zero, output, 1: result equals 0.
REQ-013 SHALL have port err, output, 1: op was illegal.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR by 1, 7 MUL. Opcodes 8..15 are illegal.
REQ-015 A transfer SHALL occur on an edge where in_valid and in_ready are both 1; a, b and op SHALL be captured on that edge.
REQ-016 The FSM SHALL have states IDLE, MUL and HOLD.
  - IDLE: in_ready = !out_valid || out_ready.
  - MUL and HOLD: in_ready = 0.
REQ-017 Single-cycle ops (0..6 and illegal) accepted on edge N SHALL present out_valid=1 and the result after edge N (one-cycle latency). The FSM stays in IDLE.
REQ-018 ADD SHALL produce result[WIDTH:0] = a+b; bit WIDTH is also the carry output.
REQ-019 SUB SHALL produce result[WIDTH-1:0] = a-b mod 2^WIDTH, with result[WIDTH] = carry = (a<b).
REQ-020 AND, OR and XOR SHALL set carry=0.
REQ-021 SHL and SHR SHALL shift a by one bit and set carry to the bit shifted out.
REQ-022 For every op except MUL, result bits above WIDTH SHALL be 0.
REQ-023 MUL SHALL be a shift-add over exactly WIDTH iterations:
  - accepted on edge N, the FSM moves IDLE->MUL;
  - after edge N+WIDTH it moves MUL->HOLD with out_valid=1;
  - result = a*b on the full 2*WIDTH bits, carry=0.
REQ-024 HOLD->IDLE SHALL occur on the edge where out_ready=1.
REQ-025 An illegal op SHALL produce result=0, carry=0, zero=1, err=1; err is 0 for legal ops.
REQ-026 While out_valid=1 and out_ready=0, result, carry, zero and err SHALL hold stable.
REQ-027 out_valid SHALL clear on the edge where out_ready=1, unless a new single-cycle transfer occurs on the same edge. In that case out_valid stays 1 and the new result replaces the old (back-to-back, one result per cycle).
REQ-028 Inputs SHALL be ignored while in_ready=0. A MUL in progress SHALL NOT be affected by a, b or op changing.

Reset
REQ-029 While rst=1 at an edge, the next state SHALL be: state=IDLE, out_valid=0, result=0, carry=0, zero=0, err=0, multiplier datapath cleared. in_ready is then 1 (combinational from IDLE and out_valid=0).
REQ-030 Reset asserted mid-MUL or in HOLD SHALL discard the operation; no result is delivered after reset.
REQ-031 rst SHALL take priority over any simultaneous transfer.

Structure
REQ-032 Package seq_alu_pkg SHALL hold the opcode constants (OP_ADD..OP_MUL) and the FSM state encoding.
REQ-033 The multiplier SHALL be the sub-module seq_alu_mul:
  - ports: clk, rst, start, a, b, done, product;
  - parametrised by WIDTH;
  - all other ops are implemented inline in seq_alu.

Verification (WIDTH=8)
REQ-034 ADD: a=5, b=5, op=0, out_ready=1 -> one cycle later out_valid=1, result=10, carry=0, zero=0.
REQ-035 SUB: a=5, b=4, op=1 -> result=1, carry=0. Then a=4, b=5, op=1 -> result=0x1FF, carry=1.
REQ-036 MUL: a=255, b=255, op=7 -> in_ready=0 for 8 cycles; out_valid rises after edge N+8 with result=0xFE01. XOR a=5, b=5, op=4 -> result=0, zero=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles after an ADD of 200+100 -> result=300 (carry=1) held stable and in_ready=0 throughout; then a transfer on the same edge as out_ready=1 yields a next result the following cycle.
REQ-038 Illegal op: a=1, b=1, op=4'hF -> result=0, zero=1, err=1.
REQ-039 Reset mid-MUL: rst=1 at the 4th MUL cycle -> next cycle out_valid=0, in_ready=1, and no result appears afterwards.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Opcodes 8..15 are the illegal half of the opcode space.
   function automatic logic op_is_legal(input logic [3:0] op_v);
      return (op_v[3] == 1'b0);
   endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: one iteration on the start edge, WIDTH-1 more after it,
// then a one-cycle done pulse with the full-width product held in product.
module seq_alu_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [2*WIDTH-1:0] a_ext;

   assign a_ext = {{WIDTH{1'b0}}, a};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            // Bit 0 of b is consumed on the start edge itself.
            acc_q    <= b[0] ? a_ext : '0;
            mcand_q  <= a_ext << 1;
            mplier_q <= b >> 1;
            cnt_q    <= CW'(WIDTH - 1);
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            if (mplier_q[0]) begin
               acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done    = done_q;
   assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; MUL is delegated to seq_alu_mul.
//   state   | meaning
//   IDLE    | accepting bundles; single-cycle results delivered from here
//   MUL     | multiplier iterating, inputs ignored
//   HOLD    | product presented, waiting for out_ready
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [3:0]           op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 zero,
   output logic                 err
);

   state_e             state_q;
   logic               out_valid_q;
   logic [2*WIDTH-1:0] result_q;
   logic               carry_q;
   logic               zero_q;
   logic               err_q;

   logic               xfer;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] alu_res_d;
   logic               alu_carry_d;
   logic               alu_err_d;

   assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign xfer      = in_valid && in_ready;
   assign mul_start = xfer && (op == OP_MUL);

   // Bit WIDTH of the difference is the borrow, i.e. a < b.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      alu_res_d   = '0;
      alu_carry_d = 1'b0;
      alu_err_d   = !op_is_legal(op);
      case (op)
         OP_ADD: begin
            alu_res_d[WIDTH:0] = sum;
            alu_carry_d        = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res_d[WIDTH:0] = diff;
            alu_carry_d        = diff[WIDTH];
         end
         OP_AND: alu_res_d[WIDTH-1:0] = a & b;
         OP_OR:  alu_res_d[WIDTH-1:0] = a | b;
         OP_XOR: alu_res_d[WIDTH-1:0] = a ^ b;
         OP_SHL: begin
            alu_res_d[WIDTH-1:0] = {a[WIDTH-2:0], 1'b0};
            alu_carry_d          = a[WIDTH-1];
         end
         OP_SHR: begin
            alu_res_d[WIDTH-1:0] = {1'b0, a[WIDTH-1:1]};
            alu_carry_d          = a[0];
         end
         default: ;
      endcase
   end

   seq_alu_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (xfer) begin
                  if (op == OP_MUL) begin
                     state_q     <= ST_MUL;
                     out_valid_q <= 1'b0;
                  end else begin
                     out_valid_q <= 1'b1;
                     result_q    <= alu_res_d;
                     carry_q     <= alu_carry_d;
                     zero_q      <= (alu_res_d == '0);
                     err_q       <= alu_err_d;
                  end
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
                  result_q    <= mul_product;
                  carry_q     <= 1'b0;
                  zero_q      <= (mul_product == '0);
                  err_q       <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8: vector table, corner sequences,
// and random traffic checked against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [3:0]     op;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic           carry;
   logic           zero;
   logic           err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .err       (err)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  op;
      logic [15:0] res;
      logic        c;
      logic        z;
      logic        e;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [7:0] ia, input logic [7:0] ib,
                               input logic [3:0] iop, input logic [15:0] r,
                               input logic c, input logic z, input logic e);
      vec_t v;
      v.a = ia; v.b = ib; v.op = iop; v.res = r; v.c = c; v.z = z; v.e = e;
      return v;
   endfunction

   // Returns {out_valid, err, zero, carry, result} as the spec's rules define it.
   function automatic logic [19:0] model(input int ia, input int ib, input int iop);
      int   r;
      logic c;
      logic e;
      r = 0; c = 1'b0; e = 1'b0;
      case (iop)
         0: begin r = ia + ib; c = (r > 255); end
         1: begin r = ((ia - ib + 256) % 256) + ((ia < ib) ? 256 : 0); c = (ia < ib); end
         2: r = ia & ib;
         3: r = ia | ib;
         4: r = ia ^ ib;
         5: begin r = (ia * 2) % 256; c = (ia >= 128); end
         6: begin r = ia / 2; c = ((ia % 2) == 1); end
         7: r = ia * ib;
         default: e = 1'b1;
      endcase
      return {1'b1, e, (r == 0), c, 16'(r)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] top,
                         output logic [19:0] got, output int lat);
      wait_ready();
      a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      got = {out_valid, err, zero, carry, result};
   endtask

   initial begin
      logic [19:0] got;
      int          lat;
      int          nrdy;
      int          seen;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [3:0]  rop;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {12'd0, out_valid, err, zero, carry, result}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      vecs.push_back(mk(8'd5,   8'd5,   4'd0, 16'd10,    1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'd5,   8'd4,   4'd1, 16'd1,     1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'd4,   8'd5,   4'd1, 16'h01FF,  1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(8'd200, 8'd100, 4'd0, 16'd300,   1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(8'd255, 8'd1,   4'd0, 16'h0100,  1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(8'd0,   8'd0,   4'd0, 16'd0,     1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(8'd7,   8'd7,   4'd1, 16'd0,     1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(8'hF0,  8'h3C,  4'd2, 16'h0030,  1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'hF0,  8'h0F,  4'd3, 16'h00FF,  1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'd5,   8'd5,   4'd4, 16'd0,     1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(8'h81,  8'h00,  4'd5, 16'h0002,  1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(8'h40,  8'hFF,  4'd5, 16'h0080,  1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'h81,  8'h00,  4'd6, 16'h0040,  1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(8'd1,   8'd1,   4'hF, 16'd0,     1'b0, 1'b1, 1'b1));
      vecs.push_back(mk(8'd9,   8'd3,   4'h8, 16'd0,     1'b0, 1'b1, 1'b1));

      foreach (vecs[i]) begin
         do_txn(vecs[i].a, vecs[i].b, vecs[i].op, got, lat);
         chk($sformatf("vec%0d", i), {12'd0, got},
             {12'd0, 1'b1, vecs[i].e, vecs[i].z, vecs[i].c, vecs[i].res});
         chk($sformatf("vec%0d_latency", i), lat, 0);
      end

      // MUL 255*255 with junk on the inputs while it runs.
      wait_ready();
      a = 8'd255; b = 8'd255; op = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      lat = 0; nrdy = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) nrdy++;
         a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); in_valid = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("mul_latency", lat, 8);
      chk("mul_in_ready_busy", nrdy, 0);
      chk("mul_in_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("mul_result", {12'd0, out_valid, err, zero, carry, result}, {12'd0, 4'b1000, 16'hFE01});
      @(posedge clk); #1;
      chk("mul_hold_release", {31'd0, out_valid}, 32'd0);

      // Backpressure on an ADD 200+100.
      wait_ready();
      a = 8'd200; b = 8'd100; op = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 8'd9; b = 8'd9; op = 4'd1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d", i), {12'd0, out_valid, err, zero, carry, result},
             {12'd0, 4'b1001, 16'd300});
         chk($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      a = 8'd7; b = 8'd8; op = 4'd0; out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_result", {12'd0, out_valid, err, zero, carry, result}, {12'd0, 4'b1000, 16'd15});
      @(posedge clk); #1;
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Reset on the 4th MUL cycle discards the product.
      wait_ready();
      a = 8'd3; b = 8'd3; op = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mul_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mul_in_ready", {31'd0, in_ready}, 32'd1);
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("rst_mul_no_result", seen, 0);

      // Reset wins over a simultaneous transfer.
      wait_ready();
      a = 8'd1; b = 8'd2; op = 4'd0; in_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_priority", {12'd0, out_valid, err, zero, carry, result}, 32'd0);

      for (int i = 0; i < 100; i++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rop = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
         do_txn(ra, rb, rop, got, lat);
         chk($sformatf("rand%0d a=%0d b=%0d op=%0d", i, ra, rb, rop), {12'd0, got},
             {12'd0, model(int'(ra), int'(rb), int'(rop))});
         chk($sformatf("rand%0d_latency", i), lat, (rop == 4'd7) ? 8 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
